// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// The FETCH_TIMEOUT_EN macro affects only fetch_sequencer itself.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 64'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus plus the issue handshake to decode/execute.
// The master modport is the sequencer side.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;
  logic [ILEN-1:0] instr;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_sequencer_pc_next_unit.sv
// Combinational next-PC: branch target (word offset scaled to bytes) or
// sequential increment, all modulo 2^64.
module pc_next_unit
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] SignExt,
  input  logic            take,
  output logic [XLEN-1:0] next_pc
);

  logic signed [XLEN-1:0] offset;

  // Shifting left by two drops the offset's top two bits by construction.
  assign offset  = take ? signed'({SignExt[XLEN-3:0], 2'b00}) : signed'(PC_INCR);
  assign next_pc = pc + unsigned'(offset);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: IDLE -> FETCH -> ISSUE -> FETCH ...
// Optional macro FETCH_TIMEOUT_EN enables the fetch-wait timeout and FAULT state.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR   = 64'h0,
  parameter int unsigned     TIMEOUT_CYCLES = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  fetch_sequencer_if.master bus,
  input  logic              Branch,
  input  logic              ALUZero,
  input  logic [XLEN-1:0]   SignExt,
  output logic [XLEN-1:0]   pc,
  output logic [31:0]       retired_cnt,
  output logic              fault
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [31:0]     retired_q, retired_d;
  logic [XLEN-1:0] next_pc;
  logic            req;
  logic            valid;
  logic [31:0]     tmo_q, tmo_d;

  pc_next_unit u_pc_next (
    .pc      (pc_q),
    .SignExt (SignExt),
    .take    (Branch & ALUZero),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    tmo_d     = '0;
    req       = 1'b0;
    valid     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = ISSUE;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          // tmo_q counts completed ack-less FETCH cycles before this one.
          if (tmo_q == TIMEOUT_CYCLES - 32'd1) state_d = FAULT;
          else                                  tmo_d   = tmo_q + 32'd1;
`else
          tmo_d = tmo_q;
`endif
        end
      end
      ISSUE: begin
        valid = 1'b1;
        if (bus.instr_ready) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid;
  assign pc              = pc_q;
  assign retired_cnt     = retired_q;

`ifdef FETCH_TIMEOUT_EN
  assign fault = (state_q == FAULT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, tmo_q};
  assign fault      = 1'b0;
`endif

endmodule
